// File: rtl/nan_ser_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB first, optional even
// parity bit (enabled by defining NAN_SER_TX_PARITY_EN), stop bit; each bit lasts CLKS_PER_BIT clocks.
module nan_ser_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              out,
  output logic              busy,
  output logic              frame_done
);

`ifdef NAN_SER_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [7:0] BCNT_MAX = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] IDX_MAX  = 4'(DATA_W - 1);

  state_t            state;
  logic [7:0]        bcnt;
  logic [3:0]        idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_sh;
  logic              bit_end;
`ifdef NAN_SER_TX_PARITY_EN
  logic              par;
`endif

  assign bit_end  = (bcnt == BCNT_MAX);
  assign shreg_sh = shreg >> 1;
  assign busy     = (state != IDLE);

  // Handshake: a word is taken at a rising edge where tx_valid and tx_ready are both 1;
  // tx_ready drops at that same edge and stays low until the frame has fully ended.
  // out is registered with the next state, so it changes at the edge the state does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      out        <= 1'b1;
      tx_ready   <= 1'b0;
      frame_done <= 1'b0;
      bcnt       <= '0;
      idx        <= '0;
      shreg      <= '0;
`ifdef NAN_SER_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
`ifdef NAN_SER_TX_PARITY_EN
            par      <= ^tx_data;
`endif
            state    <= START;
            out      <= 1'b0;
            tx_ready <= 1'b0;
            bcnt     <= '0;
            idx      <= '0;
          end else begin
            out      <= 1'b1;
            tx_ready <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            bcnt  <= '0;
            state <= DATA;
            out   <= shreg[0];
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bcnt <= '0;
            if (idx == IDX_MAX) begin
`ifdef NAN_SER_TX_PARITY_EN
              state <= PARITY;
              out   <= par;
`else
              state <= STOP;
              out   <= 1'b1;
`endif
            end else begin
              idx   <= idx + 4'd1;
              shreg <= shreg_sh;
              out   <= shreg_sh[0];
            end
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
`ifdef NAN_SER_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            bcnt  <= '0;
            state <= STOP;
            out   <= 1'b1;
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            bcnt       <= '0;
            state      <= IDLE;
            out        <= 1'b1;
            tx_ready   <= 1'b1;
            frame_done <= 1'b1;
          end else begin
            bcnt <= bcnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          out   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nan_ser_tx.sv
// Bench for nan_ser_tx: two instances (CLKS_PER_BIT 4 and 1) checked every cycle
// against a frame-timeline model, plus literal frame and latency checks.
module tb_nan_ser_tx;

`ifdef NAN_SER_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int D = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] data0, data1;
  logic       valid0, valid1;
  logic       ready0, out0, busy0, done0;
  logic       ready1, out1, busy1, done1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  nan_ser_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .out(out0), .busy(busy0), .frame_done(done0)
  );

  nan_ser_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .out(out1), .busy(busy1), .frame_done(done1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cpb(input int ch);
    return (ch == 0) ? 4 : 1;
  endfunction

  function automatic int flen(input int ch);
    return (D + 2 + P) * cpb(ch);
  endfunction

  // Frame as a list of bit values, index 0 = start bit.
  function automatic logic [17:0] frame_of(input logic [7:0] d);
    logic [17:0] f;
    f = '0;
    for (int i = 0; i < D; i++) f[1 + i] = d[i];
    if (P == 1) f[1 + D] = ^d;
    f[1 + D + P] = 1'b1;
    return f;
  endfunction

  // Model: m_t is the cycle offset inside the current frame, -1 when idle.
  logic [17:0] m_bits [2];
  int          m_t    [2];
  logic        m_ready[2];
  logic        m_done [2];

  always @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (!rst_n) begin
        m_t[ch]     <= -1;
        m_ready[ch] <= 1'b0;
        m_done[ch]  <= 1'b0;
      end else if (m_ready[ch] && (ch == 0 ? valid0 : valid1)) begin
        m_bits[ch]  <= frame_of(ch == 0 ? data0 : data1);
        m_t[ch]     <= 0;
        m_ready[ch] <= 1'b0;
        m_done[ch]  <= 1'b0;
      end else if (m_t[ch] >= 0) begin
        if (m_t[ch] == flen(ch) - 1) begin
          m_t[ch]     <= -1;
          m_ready[ch] <= 1'b1;
          m_done[ch]  <= 1'b1;
        end else begin
          m_t[ch]    <= m_t[ch] + 1;
          m_done[ch] <= 1'b0;
        end
      end else begin
        m_ready[ch] <= 1'b1;
        m_done[ch]  <= 1'b0;
      end
    end
  end

  function automatic logic exp_out(input int ch);
    if (m_t[ch] < 0) return 1'b1;
    return m_bits[ch][m_t[ch] / cpb(ch)];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out0",   {31'd0, out0},   {31'd0, exp_out(0)});
      check("ready0", {31'd0, ready0}, {31'd0, m_ready[0]});
      check("busy0",  {31'd0, busy0},  {31'd0, (m_t[0] >= 0)});
      check("done0",  {31'd0, done0},  {31'd0, m_done[0]});
      check("out1",   {31'd0, out1},   {31'd0, exp_out(1)});
      check("ready1", {31'd0, ready1}, {31'd0, m_ready[1]});
      check("busy1",  {31'd0, busy1},  {31'd0, (m_t[1] >= 0)});
      check("done1",  {31'd0, done1},  {31'd0, m_done[1]});
    end
  end

  // driver: called at a negedge, returns at the negedge just after the acceptance edge
  task automatic send(input int ch, input logic [7:0] d, input bit hold);
    bit ok;
    ok = 0;
    if (ch == 0) begin valid0 = 1'b1; data0 = d; end
    else begin valid1 = 1'b1; data1 = d; end
    for (int n = 0; n < 500; n++) begin
      if (m_ready[ch]) begin
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!hold) begin
      if (ch == 0) valid0 = 1'b0;
      else valid1 = 1'b0;
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  // samples the middle of every bit of the frame just accepted
  task automatic capture(input int ch, output logic [17:0] got);
    int c;
    c = cpb(ch);
    got = '0;
    for (int j = 0; j < flen(ch); j++) begin
      if (j % c == c / 2) got[j / c] = (ch == 0) ? out0 : out1;
      @(negedge clk);
    end
    check("done_lat", {31'd0, (ch == 0 ? done0 : done1)}, 32'd1);
  endtask

`ifdef NAN_SER_TX_PARITY_EN
  localparam logic [17:0] EXP_A5 = {7'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
  localparam logic [17:0] EXP_01 = {7'd0, 1'b1, 1'b1, 8'h01, 1'b0};
  localparam logic [17:0] EXP_FF = {7'd0, 1'b1, 1'b0, 8'hFF, 1'b0};
  localparam logic [17:0] EXP_5A = {7'd0, 1'b1, 1'b0, 8'h5A, 1'b0};
  localparam logic [17:0] EXP_0F = {7'd0, 1'b1, 1'b0, 8'h0F, 1'b0};
  localparam int          B2B    = 45;
`else
  localparam logic [17:0] EXP_A5 = {8'd0, 1'b1, 8'hA5, 1'b0};
  localparam logic [17:0] EXP_01 = {8'd0, 1'b1, 8'h01, 1'b0};
  localparam logic [17:0] EXP_FF = {8'd0, 1'b1, 8'hFF, 1'b0};
  localparam logic [17:0] EXP_5A = {8'd0, 1'b1, 8'h5A, 1'b0};
  localparam logic [17:0] EXP_0F = {8'd0, 1'b1, 8'h0F, 1'b0};
  localparam int          B2B    = 41;
`endif

  initial begin
    logic [17:0] got;
    int n;
    rst_n  = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    data0  = 8'h00;
    data1  = 8'h00;

    // reset hold for 3 edges
    @(posedge clk);
    chk_en = 1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_out",   {31'd0, out0},   32'd1);
    check("rst_ready", {31'd0, ready0}, 32'd0);
    check("rst_busy",  {31'd0, busy0},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst0", {31'd0, ready0}, 32'd1);
    check("ready_after_rst1", {31'd0, ready1}, 32'd1);

    // single frames
    send(0, 8'hA5, 0);
    capture(0, got);
    check("frame_a5", {14'd0, got}, {14'd0, EXP_A5});
    send(0, 8'h01, 0);
    capture(0, got);
    check("frame_01", {14'd0, got}, {14'd0, EXP_01});

    // back-to-back with tx_data changed during the first frame
    repeat (2) @(negedge clk);
    send(0, 8'h00, 1);
    data0 = 8'hFF;
    n = 0;
    while (!ready0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_gap", n + 1, B2B);
    @(negedge clk);
    valid0 = 1'b0;
    capture(0, got);
    check("frame_ff", {14'd0, got}, {14'd0, EXP_FF});

    // reset during data bit 3
    repeat (3) @(negedge clk);
    send(0, 8'h3C, 0);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out",  {31'd0, out0},  32'd1);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_done", {31'd0, done0}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    send(0, 8'h5A, 0);
    capture(0, got);
    check("frame_5a", {14'd0, got}, {14'd0, EXP_5A});

    // one clock per bit
    send(1, 8'h0F, 0);
    capture(1, got);
    check("frame_0f_cpb1", {14'd0, got}, {14'd0, EXP_0F});

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
